// File: rtl/color_serializer_if.sv
// Nibble stream handshake between the color serializer and its consumer.
// The serializer drives value/valid; the consumer drives ready.
interface color_serializer_if;
    logic [3:0] value;
    logic       valid;
    logic       ready;

    modport master (
        output value,
        output valid,
        input  ready
    );

    modport slave (
        input  value,
        input  valid,
        output ready
    );
endinterface

// File: rtl/color_serializer.sv
// Serializes a 4*NIBBLES-bit color into 4-bit beats, MS nibble first, over a
// valid/ready handshake. Pulses done for one cycle after the final beat.
// Optional macro COLOR_SER_CHECKSUM_EN appends one beat carrying the XOR of
// all data nibbles.
module color_serializer #(
    parameter int unsigned NIBBLES = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NIBBLES-1:0]   color,
    input  logic                   load,
    output logic                   busy,
    output logic                   done,
    color_serializer_if.master     nib
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = $clog2(NIBBLES + 1);

`ifdef COLOR_SER_CHECKSUM_EN
    // Checksum beat sits at index NIBBLES, after all data beats.
    localparam logic [CntW-1:0] DataBeats = CntW'(NIBBLES);
    localparam logic [CntW-1:0] LastBeat  = CntW'(NIBBLES);
`else
    localparam logic [CntW-1:0] LastBeat  = CntW'(NIBBLES - 1);
`endif

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      value_q, value_d;
    logic [3:0]      nibble_d;

`ifdef COLOR_SER_CHECKSUM_EN
    logic [3:0]      csum_q, csum_d;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= 4'h0;
`ifdef COLOR_SER_CHECKSUM_EN
            csum_q  <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
`ifdef COLOR_SER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef COLOR_SER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d = color;
                    cnt_d   = '0;
`ifdef COLOR_SER_CHECKSUM_EN
                    csum_d  = 4'h0;
`endif
                    state_d = StSend;
                end
            end
            StSend: begin
                if (valid_q && nib.ready) begin
                    shreg_d = shreg_q << 4;
                    cnt_d   = cnt_q + CntW'(1);
`ifdef COLOR_SER_CHECKSUM_EN
                    // Register is all zeros by the checksum beat, so XOR-ing it is harmless.
                    csum_d  = csum_q ^ shreg_q[W-1 -: 4];
`endif
                    if (cnt_q == LastBeat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        nibble_d = shreg_d[W-1 -: 4];
`ifdef COLOR_SER_CHECKSUM_EN
        if (cnt_d == DataBeats) begin
            nibble_d = csum_d;
        end
`endif
        valid_d = (state_d == StSend);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        value_d = valid_d ? nibble_d : 4'h0;
    end

    assign nib.value = value_q;
    assign nib.valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_color_serializer.sv
// Scoreboard bench for color_serializer: the driver pushes expected nibbles,
// a negedge monitor pops and compares on every handshake.
module tb_color_serializer;

`ifdef COLOR_SER_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] color;
    logic        load;
    logic        busy;
    logic        done;
    logic        ready;

    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    int          stall_plan [7];
    logic [3:0]  exp_q [$];

    color_serializer_if nib_if ();
    assign nib_if.ready = ready;

    color_serializer #(.NIBBLES(6)) dut (
        .clk   (clk),
        .reset (reset),
        .color (color),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .nib   (nib_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat k of color c: data nibbles MS first, then the XOR checksum.
    function automatic logic [3:0] exp_nib(input logic [23:0] c, input int k);
        logic [3:0] x;
        if (k < 6) return c[23 - 4*k -: 4];
        x = 4'h0;
        for (int i = 0; i < 6; i++) x ^= c[23 - 4*i -: 4];
        return x;
    endfunction

    // Monitor: compares every accepted beat against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!reset) begin
            if (nib_if.valid) begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_beat: got %0h, expected none", nib_if.value);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_value", 32'(nib_if.value), 32'(e));
                    end
                end
            end else begin
                chk("idle_value_zero", 32'(nib_if.value), 32'h0);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_beat", 32'(exp_q.size()), 32'h0);
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 7; i++) stall_plan[i] = 0;
    endtask

    // Full transfer of c with stalls from stall_plan; a spurious load of ffffff
    // is raised on beat inject_beat (-1 for none) and another during DONE.
    task automatic send(input logic [23:0] c, input int inject_beat);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < NB; k++) exp_q.push_back(exp_nib(c, k));
        color = c;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        color = 24'h0;
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s < stall_plan[k]; s++) begin
                ready = 1'b0;
                tick();
                chk("stall_value", 32'(nib_if.value), 32'(exp_nib(c, k)));
                chk("stall_valid", 32'(nib_if.valid), 32'h1);
            end
            ready = 1'b1;
            if (k == inject_beat) begin
                load  = 1'b1;
                color = 24'hffffff;
            end
            chk("beat_busy", 32'(busy), 32'h1);
            chk("beat_no_done", 32'(done), 32'h0);
            tick();
            load = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'h1);
        chk("done_busy", 32'(busy), 32'h1);
        chk("done_valid_low", 32'(nib_if.valid), 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("post_done_low", 32'(done), 32'h0);
        chk("post_busy_low", 32'(busy), 32'h0);
        tick();
        chk("done_load_ignored", 32'(nib_if.valid), 32'h0);
        chk("single_done", 32'(done_cnt - d0), 32'h1);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        load  = 1'b0;
        ready = 1'b0;
        color = 24'h0;
        repeat (3) tick();
        chk("rst_valid", 32'(nib_if.valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(nib_if.valid), 32'h0);
            chk("idle_value", 32'(nib_if.value), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
        end
        ready = 1'b1;

        // Basic send, no stalls.
        clear_plan();
        send(24'hc5a0d8, -1);

        // Backpressure: 3 stalls on beat f, 1 stall on beat 3.
        clear_plan();
        stall_plan[1] = 3;
        stall_plan[4] = 1;
        send(24'h1f2e3d, -1);

        // Load during transfer must not disturb the captured color.
        clear_plan();
        send(24'hc5a0d8, 2);

        // Reset after the third beat is accepted.
        d0 = done_cnt;
        for (int k = 0; k < NB; k++) exp_q.push_back(exp_nib(24'hc5a0d8, k));
        color = 24'hc5a0d8;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(nib_if.valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_value", 32'(nib_if.value), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        ready = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'h0);
        chk("midrst_idle", 32'(busy), 32'h0);

        clear_plan();
        send(24'h000001, -1);

        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/color_serializer.md
Name: color_serializer

Overview:
- Transmit side of the nibble-entry interface: takes a full 24-bit RGB color and emits it as six 4-bit values, most-significant nibble first.
- Uses a valid/ready handshake toward the consumer. Any keypad-style color assembler can be the consumer and rebuild the color.
- Sits between the color register or picture logic and that consumer; pulses done when the last nibble is accepted.

Parameters:
- NIBBLES, 6, number of 4-bit beats per color; color input width is 4*NIBBLES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- color  input  4*NIBBLES  color word to send; sampled only on an accepted load.
- load  input  1  request to start sending color; honoured only in IDLE.
- busy  output  1  high from the cycle after an accepted load through the DONE cycle.
- value  output  4  current nibble; 4'h0 whenever valid is low.
- valid  output  1  value holds a nibble for the consumer.
- ready  input  1  consumer accepts value on a cycle where valid && ready.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset values: busy=0, value=4'h0, valid=0, done=0; FSM=IDLE; shift register and beat counter cleared.
- Reset mid-transfer aborts immediately: no done pulse, and the partial color is discarded.
- All outputs are registered.
- Storage:
  - shift register, width 4*NIBBLES;
  - beat counter, width $clog2(NIBBLES+1), unsigned.
- States: IDLE, SEND, DONE.
- IDLE:
  - valid=0, busy=0.
  - load=1 captures color into the shift register, clears the counter and goes to SEND.
  - Load is accepted at edge t; valid=1 and value=color[4*NIBBLES-1 -: 4] from t+1.
- SEND:
  - valid=1, busy=1, value=top nibble of the shift register.
  - On valid && ready: shift left by 4 (zero fill) and increment the counter.
  - If that handshake is the beat with counter==NIBBLES-1, go to DONE; valid falls the next cycle.
  - While ready=0, value and valid hold stable for any number of cycles; ready may toggle arbitrarily.
- DONE (one cycle):
  - done=1, busy=1, valid=0; then go to IDLE.
  - A load seen during DONE is ignored; the next load is accepted in the following IDLE cycle.
- load while busy (SEND or DONE) is ignored. Changes on color during SEND do not affect the nibbles already in flight.
- Best-case timing with ready held high, load accepted at edge t:
  - beats on cycles t+1..t+NIBBLES;
  - done on t+NIBBLES+1;
  - IDLE on t+NIBBLES+2.
- Consumer contract: only handshaked beats count. A change of value without valid is never a beat.

Optional Feature:
- Macro COLOR_SER_CHECKSUM_EN.
- Defined:
  - One extra beat follows the NIBBLES data beats; its value is the XOR of all data nibbles sent.
  - It uses the same handshake and stall rules as data beats.
  - DONE is entered after the checksum beat is accepted, so a transfer is NIBBLES+1 beats.
  - The XOR accumulator clears on load and on reset.
- Undefined: exactly NIBBLES beats; no accumulator logic is present.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release, hold load=0 for 10 cycles → valid=0, value=0, busy=0, done=0 throughout.
- Basic send: color=24'hc5a0d8, load pulse, ready=1 → beats c,5,a,0,d,8 on six consecutive cycles starting the cycle after load; done=1 for one cycle right after beat 8; busy low the cycle after that.
- Backpressure: color=24'h1f2e3d, ready=0 for 3 cycles on beat 2 and for 1 cycle on beat 5 → value holds f then 3 while stalled; six accepted beats 1,f,2,e,3,d; done after the last beat only.
- Ignored load / stable capture: during the transfer of 24'hc5a0d8, pulse load with color=24'hffffff → sent stream still c5a0d8 and exactly one done pulse.
- Reset mid-operation: assert reset after beat 3 is accepted → the next cycle shows valid=0, busy=0, done=0; a new load of 24'h000001 then sends 0,0,0,0,0,1 correctly.
- Checksum (COLOR_SER_CHECKSUM_EN defined): color=24'hc5a0d8 → seven beats c,5,a,0,d,8,6 (6 = XOR of the six data nibbles); done after beat 6.
